// File: rtl/store_checker.sv
`default_nettype none
// ============================================================================
//  Module      : store_checker
//  Description : Watches the CPU data-memory store bus and latches a sticky
//                pass/fail verdict with diagnostic counters and last store.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_checker #(
    parameter logic [31:0] PASS_ADDR    = 32'd84,
    parameter logic [31:0] PASS_DATA    = 32'd7,
    parameter logic [31:0] SCRATCH_ADDR = 32'd80,
    parameter int          TIMEOUT      = 1000,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             memwrite,
    input  logic [31:0]      dataadr,
    input  logic [31:0]      writedata,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] store_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [31:0]      last_adr,
    output logic [31:0]      last_data
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    localparam logic [1:0]       c_CODE_NONE    = 2'd0;
    localparam logic [1:0]       c_CODE_STRAY   = 2'd1;
    localparam logic [1:0]       c_CODE_BADDATA = 2'd2;
    localparam logic [1:0]       c_CODE_TIMEOUT = 2'd3;
    localparam logic [CNT_W-1:0] c_CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q,       state_d;
    logic               done_q,        done_d;
    logic               pass_q,        pass_d;
    logic               fail_q,        fail_d;
    logic [1:0]         fail_code_q,   fail_code_d;
    logic [CNT_W-1:0]   store_count_q, store_count_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic [31:0]        last_adr_q,    last_adr_d;
    logic [31:0]        last_data_q,   last_data_d;
    logic               store_decides;

    always_comb begin
        state_d       = state_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        fail_code_d   = fail_code_q;
        store_count_d = store_count_q;
        cycle_count_d = cycle_count_q;
        last_adr_d    = last_adr_q;
        last_data_d   = last_data_q;
        store_decides = 1'b0;

        if (clear) begin
            state_d       = ST_RUN;
            pass_d        = 1'b0;
            fail_d        = 1'b0;
            fail_code_d   = c_CODE_NONE;
            store_count_d = '0;
            cycle_count_d = '0;
            last_adr_d    = '0;
            last_data_d   = '0;
        end else if (state_q == ST_RUN) begin
            if (cycle_count_q != c_CNT_MAX) begin
                cycle_count_d = cycle_count_q + 1'b1;
            end
            if (memwrite) begin
                if (store_count_q != c_CNT_MAX) begin
                    store_count_d = store_count_q + 1'b1;
                end
                last_adr_d  = dataadr;
                last_data_d = writedata;
                if (dataadr == PASS_ADDR) begin
                    store_decides = 1'b1;
                    if (writedata == PASS_DATA) begin
                        state_d = ST_PASS;
                        pass_d  = 1'b1;
                    end else begin
                        state_d     = ST_FAIL;
                        fail_d      = 1'b1;
                        fail_code_d = c_CODE_BADDATA;
                    end
                end else if (dataadr != SCRATCH_ADDR) begin
                    store_decides = 1'b1;
                    state_d       = ST_FAIL;
                    fail_d        = 1'b1;
                    fail_code_d   = c_CODE_STRAY;
                end
            end
            // A scratch store is not a verdict, so it cannot mask the timeout.
            if (!store_decides && (cycle_count_q == c_TIMEOUT_LAST)) begin
                state_d     = ST_FAIL;
                fail_d      = 1'b1;
                fail_code_d = c_CODE_TIMEOUT;
            end
        end
        done_d = pass_d | fail_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            fail_code_q   <= c_CODE_NONE;
            store_count_q <= '0;
            cycle_count_q <= '0;
            last_adr_q    <= '0;
            last_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            fail_code_q   <= fail_code_d;
            store_count_q <= store_count_d;
            cycle_count_q <= cycle_count_d;
            last_adr_q    <= last_adr_d;
            last_data_q   <= last_data_d;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_code   = fail_code_q;
    assign store_count = store_count_q;
    assign cycle_count = cycle_count_q;
    assign last_adr    = last_adr_q;
    assign last_data   = last_data_q;

endmodule
`default_nettype wire

// File: tb/tb_store_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_checker
//  Description : Self-checking bench for store_checker (TIMEOUT shortened to 20).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_checker;

    localparam int c_MAXC = 65535;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        done, pass, fail;
    logic [1:0]  fail_code;
    logic [15:0] store_count, cycle_count;
    logic [31:0] last_adr, last_data;

    store_checker #(
        .PASS_ADDR   (32'd84),
        .PASS_DATA   (32'd7),
        .SCRATCH_ADDR(32'd80),
        .TIMEOUT     (20),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .memwrite   (memwrite),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .fail_code  (fail_code),
        .store_count(store_count),
        .cycle_count(cycle_count),
        .last_adr   (last_adr),
        .last_data  (last_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference: 0 = checking, 1 = passed, 2 = failed
    int          m_state;
    logic [1:0]  m_code;
    int          m_sc, m_cc;
    logic [31:0] m_la, m_ld;

    function automatic logic [100:0] dut_vec();
        return {done, pass, fail, fail_code, store_count, cycle_count, last_adr, last_data};
    endfunction

    function automatic logic [100:0] model_vec();
        return {m_state != 0, m_state == 1, m_state == 2, m_code,
                16'(m_sc), 16'(m_cc), m_la, m_ld};
    endfunction

    task automatic model_reset();
        m_state = 0; m_code = 2'd0; m_sc = 0; m_cc = 0; m_la = '0; m_ld = '0;
    endtask

    task automatic model_edge(input logic clr, input logic mw,
                              input logic [31:0] a, input logic [31:0] d);
        int old_cc;
        bit decided;
        old_cc  = m_cc;
        decided = 0;
        if (clr) begin
            model_reset();
        end else if (m_state == 0) begin
            if (m_cc < c_MAXC) m_cc++;
            if (mw) begin
                if (m_sc < c_MAXC) m_sc++;
                m_la = a;
                m_ld = d;
                if (a == 32'd84) begin
                    decided = 1;
                    if (d == 32'd7) m_state = 1;
                    else begin m_state = 2; m_code = 2'd2; end
                end else if (a != 32'd80) begin
                    decided = 1;
                    m_state = 2;
                    m_code  = 2'd1;
                end
            end
            if (!decided && old_cc == 19) begin
                m_state = 2;
                m_code  = 2'd3;
            end
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic drive(input logic clr, input logic mw,
                         input logic [31:0] a, input logic [31:0] d);
        clear = clr; memwrite = mw; dataadr = a; writedata = d;
        @(posedge clk);
        model_edge(clr, mw, a, d);
        @(negedge clk);
        clear = 1'b0; memwrite = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; clear = 1'b0; memwrite = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (dut_vec() !== 101'd0) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), 101'd0);
        end
        reset = 1'b1;
    endtask

    task automatic test_pass_sequence();
        apply_reset();
        drive(1'b0, 1'b1, 32'd80, 32'd0);
        checks++;
        if ({done, pass, fail, store_count} !== {3'b000, 16'd1}) begin
            failures++;
            $display("FAIL scratch_store: got %b/%0d expected 000/1", {done, pass, fail}, store_count);
        end
        drive(1'b0, 1'b1, 32'd84, 32'd7);
        checks++;
        if ({done, pass, fail, fail_code, store_count, last_adr, last_data} !==
            {3'b110, 2'd0, 16'd2, 32'd84, 32'd7}) begin
            failures++;
            $display("FAIL pass_store: got %b %0d %0d %0d %0d expected 110 0 2 84 7",
                     {done, pass, fail}, fail_code, store_count, last_adr, last_data);
        end
    endtask

    task automatic test_stray();
        apply_reset();
        drive(1'b0, 1'b1, 32'd88, 32'd5);
        checks++;
        if ({done, pass, fail, fail_code, last_adr} !== {3'b101, 2'd1, 32'd88}) begin
            failures++;
            $display("FAIL stray_store: got %b %0d %0d expected 101 1 88",
                     {done, pass, fail}, fail_code, last_adr);
        end
        drive(1'b0, 1'b1, 32'd84, 32'd7);
        checks++;
        if ({pass, fail, fail_code, store_count, last_adr} !== {2'b01, 2'd1, 16'd1, 32'd88}) begin
            failures++;
            $display("FAIL fail_sticky: got %b %0d %0d %0d expected 01 1 1 88",
                     {pass, fail}, fail_code, store_count, last_adr);
        end
    endtask

    task automatic test_wrong_data();
        apply_reset();
        drive(1'b0, 1'b1, 32'd84, 32'd6);
        checks++;
        if ({done, pass, fail, fail_code, last_data} !== {3'b101, 2'd2, 32'd6}) begin
            failures++;
            $display("FAIL wrong_data: got %b %0d %0d expected 101 2 6",
                     {done, pass, fail}, fail_code, last_data);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        repeat (19) drive(1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if ({fail, cycle_count} !== {1'b0, 16'd19}) begin
            failures++;
            $display("FAIL timeout_early: got fail=%b cc=%0d expected 0 19", fail, cycle_count);
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if ({done, fail, fail_code, cycle_count} !== {2'b11, 2'd3, 16'd20}) begin
            failures++;
            $display("FAIL timeout_edge: got %b %0d %0d expected 11 3 20",
                     {done, fail}, fail_code, cycle_count);
        end
        repeat (3) drive(1'b0, 1'b1, 32'd80, 32'd1);
        checks++;
        if ({cycle_count, store_count, last_adr} !== {16'd20, 16'd0, 32'd0}) begin
            failures++;
            $display("FAIL timeout_frozen: got cc=%0d sc=%0d la=%0d expected 20 0 0",
                     cycle_count, store_count, last_adr);
        end
        apply_reset();
        repeat (19) drive(1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b0, 1'b1, 32'd84, 32'd7);
        checks++;
        if ({pass, fail, fail_code} !== {2'b10, 2'd0}) begin
            failures++;
            $display("FAIL pass_beats_timeout: got %b %0d expected 10 0", {pass, fail}, fail_code);
        end
        apply_reset();
        repeat (19) drive(1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b0, 1'b1, 32'd80, 32'd9);
        checks++;
        if ({fail, fail_code, store_count} !== {1'b1, 2'd3, 16'd1}) begin
            failures++;
            $display("FAIL scratch_no_mask: got %b %0d %0d expected 1 3 1", fail, fail_code, store_count);
        end
    endtask

    task automatic test_clear_and_async_reset();
        apply_reset();
        drive(1'b0, 1'b1, 32'd84, 32'd7);
        drive(1'b1, 1'b1, 32'd88, 32'd5);
        checks++;
        if (dut_vec() !== 101'd0) begin
            failures++;
            $display("FAIL clear_outputs: got %h expected %h", dut_vec(), 101'd0);
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if ({done, cycle_count} !== {1'b0, 16'd1}) begin
            failures++;
            $display("FAIL clear_resume: got done=%b cc=%0d expected 0 1", done, cycle_count);
        end
        repeat (3) drive(1'b0, 1'b1, 32'd80, 32'd3);
        checks++;
        if (store_count !== 16'd3) begin
            failures++;
            $display("FAIL pre_reset_count: got %0d expected 3", store_count);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 101'd0) begin
            failures++;
            $display("FAIL async_reset: got %h expected %h", dut_vec(), 101'd0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_no_write();
        apply_reset();
        repeat (10) begin
            dataadr = 32'd84; writedata = 32'd7;
            drive(1'b0, 1'b0, 32'd84, 32'd7);
        end
        checks++;
        if ({done, store_count, cycle_count} !== {1'b0, 16'd0, 16'd10}) begin
            failures++;
            $display("FAIL no_write: got done=%b sc=%0d cc=%0d expected 0 0 10",
                     done, store_count, cycle_count);
        end
    endtask

    task automatic test_random();
        logic        mw, clr;
        logic [31:0] a, d;
        int          sel;
        for (int ep = 0; ep < 40; ep++) begin
            if ($urandom_range(0, 1) == 0) apply_reset();
            else drive(1'b1, 1'b0, 32'd0, 32'd0);
            for (int c = 0; c < int'($urandom_range(1, 30)); c++) begin
                clr = ($urandom_range(0, 24) == 0);
                mw  = ($urandom_range(0, 2) != 0);
                sel = int'($urandom_range(0, 9));
                a   = (sel < 6) ? 32'd80 : (sel < 8) ? 32'd84 : (sel == 8) ? 32'd88 : 32'($urandom);
                d   = ($urandom_range(0, 1) == 0) ? 32'd7 : 32'($urandom_range(0, 15));
                drive(clr, mw, a, d);
                checks++;
                if (dut_vec() !== model_vec()) begin
                    failures++;
                    $display("FAIL random_ep%0d_cyc%0d: got %h expected %h", ep, c, dut_vec(), model_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pass_sequence();
        test_stray();
        test_wrong_data();
        test_timeout();
        test_clear_and_async_reset();
        test_no_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
